board_input: RTL
================

# board_input

Board-level input capture block: the input-side counterpart of the seven-segment display path. It synchronizes and debounces the board push-buttons and slide switches and generates one-cycle press pulses and sticky press flags. It exposes the result to the CPU through a small registered read port. It sits beside the display driver in the board top level, runs on the undivided board clock, and feeds the CPU or any debug logic that needs user input.

## Interface
- `N_BTN`, default 4: number of push-buttons, range 1..32.
- `N_SW`, default 16: number of slide switches, range 1..32.
- `DEBOUNCE_CYCLES`, default 2000000: number of consecutive clock cycles an input must hold a new value before it is accepted. Minimum 2. Benches use 4.
- `clk`, input, 1: board clock.
- `rst`, input, 1: synchronous, active-high reset.
- `btn_raw`, input, N_BTN: asynchronous button pins, active-high.
- `sw_raw`, input, N_SW: asynchronous switch pins.
- `btn_level`, output, N_BTN: debounced button state.
- `btn_press`, output, N_BTN: one-cycle pulse on each debounced 0->1 button transition.
- `sw_level`, output, N_SW: debounced switch state.
- `rd_en`, input, 1: CPU read strobe, 1 cycle.
- `rd_addr`, input, 2: register select.
- `rd_data`, output, 32: registered read data.
- `rd_valid`, output, 1: high exactly one cycle after each `rd_en`.

## Operation
- Each raw bit passes through a 2-flop synchronizer (`s1`, `s2`), then a per-bit debounce cell holding `stable` and `cnt`. The counter width is `$clog2(DEBOUNCE_CYCLES)`.
- Debounce cell behaviour, evaluated each cycle:
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`. Any return to the old value restarts the count from 0.
- Press pulse and flag:
  - `btn_press[i]` is a registered `stable_next & ~stable`. It is high only during the first cycle in which `btn_level[i]` reads 1.
  - Releases (1->0) produce no pulse.
  - `press_flag[i]` sets on `btn_press[i]` and stays set until cleared by a read.
- `press_count` is a 32-bit counter incremented on `btn_press[0]`. It wraps from 0xFFFF_FFFF to 0.
- Register map, read at `rd_en` and returned registered on the next cycle:
  - 0: `sw_level`, zero-extended.
  - 1: `press_flag`, zero-extended. This read clears all flags (read-to-clear).
  - 2: `btn_level`, zero-extended.
  - 3: `press_count`.
- Read-to-clear collision: if `btn_press[i]` fires in the same cycle as a clearing read, the returned data shows the pre-clear value and `press_flag[i]` ends up 1, so the set wins. No press is lost.
- `rd_data` holds its last value when `rd_valid` is 0.
- Back-to-back `rd_en` on consecutive cycles is legal. Each read is answered one cycle later.

## Timing
- Reset values, all taking effect at the first `clk` edge with `rst` high:
  - `btn_level`, `sw_level`, `btn_press`, `rd_valid`: 0.
  - `rd_data`: 32'h0.
  - Internal: synchronizer flops, `stable`, `cnt`, `press_flag`, `press_count`: 0.
- Input latency: raw bit is sampled new at edge k, `s2` changes at k+1, and `stable` / `*_level` change at edge k+1+DEBOUNCE_CYCLES, provided the raw bit is held throughout. With DEBOUNCE_CYCLES=4 this is edge k+5.
- `btn_press` is asserted in the cycle following edge k+1+DEBOUNCE_CYCLES and deasserts one cycle later.
- Read latency is exactly 1 cycle: `rd_en` sampled at edge n gives `rd_valid`=1 and `rd_data` valid after edge n+1.
- Reset asserted mid-debounce or mid-read: all state clears at that edge. A read accepted on the reset edge produces no `rd_valid`. Inputs already high at reset release are re-debounced from 0 and produce a press pulse.

## Structure
- Shared constants header holds the register addresses (`ADDR_SW`=0, `ADDR_FLAGS`=1, `ADDR_BTN`=2, `ADDR_COUNT`=3).
- One sub-module, `debounce_cell` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `din_raw`, `dout`). It contains the synchronizer, counter and stable register, and is instantiated N_BTN+N_SW times via generate.
- The top contains the edge detection, flags, counter and read port.

## Test plan
- **Reset:** hold `rst` 2 cycles with all raw inputs at 1 -> all outputs 0 during reset. After release, with DEBOUNCE_CYCLES=4, `btn_level`=4'hF five edges after release and `btn_press`=4'hF for one cycle.
- **Glitch reject:** `btn_raw[1]` high for 3 cycles, then low -> `btn_level` stays 0 and no pulse. Held for 4+2 cycles -> `btn_level[1]`=1 and exactly one `btn_press[1]` pulse.
- **Bounce:** toggle `sw_raw[5]` 1,0,1,0,1 at 2-cycle intervals, then hold 1 -> `sw_level[5]` rises once, 5 edges after the final rising sample. Register 0 read then returns 32'h0000_0020.
- **Read-to-clear:** press btn2, then read addr 1 -> `rd_data`=32'h4 and `rd_valid` 1 cycle later. Read addr 1 again -> 32'h0.
- **Collision:** align `btn_press[0]` with a clearing read of addr 1 while flags=4'h2 -> returned data 32'h2. A next read returns 32'h1.
- **Counter wrap:** force `press_count`=32'hFFFF_FFFF, press btn0 -> read addr 3 returns 32'h0.

Source files
------------

// File: rtl/board_input_pkg.sv
// board_input_pkg: read-port register addresses shared by the input capture block.
package board_input_pkg;
  typedef enum logic [1:0] {
    ADDR_SW    = 2'd0,
    ADDR_FLAGS = 2'd1,
    ADDR_BTN   = 2'd2,
    ADDR_COUNT = 2'd3
  } rd_addr_e;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchronizer plus hold-time debounce for one raw input.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1_q, s2_q, stable_q, stable_d, done;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    done     = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    stable_d = (s2_q != stable_q && done) ? s2_q : stable_q;
    // any return to the stable value restarts the hold count
    cnt_d    = (s2_q == stable_q || done) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= din_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign dout = stable_q;
endmodule

// File: rtl/board_input.sv
// board_input: debounced buttons/switches, press pulses, sticky flags and CPU read port.
module board_input
  import board_input_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_SW-1:0]  sw_level,
  input  logic             rd_en,
  input  logic [1:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic             rd_valid
);
  logic [N_BTN-1:0] btn_prev_q, flag_q, flag_d;
  logic [31:0] press_count_q, press_count_d, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_clr;
  rd_addr_e addr;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk(clk), .rst(rst), .din_raw(btn_raw[i]), .dout(btn_level[i])
    );
  end
  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk(clk), .rst(rst), .din_raw(sw_raw[j]), .dout(sw_level[j])
    );
  end
  // high only in the first cycle the debounced level reads 1
  assign btn_press = btn_level & ~btn_prev_q;
  always_comb begin
    addr          = rd_addr_e'(rd_addr);
    rd_clr        = rd_en && addr == ADDR_FLAGS;
    // a press coinciding with a clearing read survives the clear
    flag_d        = (rd_clr ? '0 : flag_q) | btn_press;
    press_count_d = press_count_q + 32'(btn_press[0]);
    rd_data_d     = !rd_en              ? rd_data_q :
                    addr == ADDR_SW     ? 32'(sw_level) :
                    addr == ADDR_FLAGS  ? 32'(flag_q) :
                    addr == ADDR_BTN    ? 32'(btn_level) : press_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev_q    <= '0;
      flag_q        <= '0;
      press_count_q <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      btn_prev_q    <= btn_level;
      flag_q        <= flag_d;
      press_count_q <= press_count_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_en;
    end
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule
